// File: rtl/bcd_pkg.sv
// Shared definitions for the handshaked binary-to-BCD converter:
// FSM encoding, BCD digit width and a constant clog2 helper.
package bcd_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((32'sd1 <<< res) < value) begin
      res = res + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/binary_to_bcd_hs_dabble_step.sv
// One double-dabble step: add 3 to every digit above 4, then shift the
// whole BCD vector left by one with carry-in; the bit leaving the top is carry-out.
module bcd_dabble_step
  import bcd_pkg::*;
#(
  parameter int DIGITS = 5
) (
  input  logic [BCD_W*DIGITS-1:0] bcd_i,
  input  logic                    cin_i,
  output logic [BCD_W*DIGITS-1:0] bcd_o,
  output logic                    cout_o
);

  logic [BCD_W*DIGITS-1:0] adj_s;

  // Per-digit add-3 correction ahead of the shift
  always_comb begin
    adj_s = bcd_i;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_i[i*BCD_W +: BCD_W] > 4'd4) begin
        adj_s[i*BCD_W +: BCD_W] = bcd_i[i*BCD_W +: BCD_W] + 4'd3;
      end else begin
        adj_s[i*BCD_W +: BCD_W] = bcd_i[i*BCD_W +: BCD_W];
      end
    end
  end

  assign bcd_o  = {adj_s[BCD_W*DIGITS-2:0], cin_i};
  assign cout_o = adj_s[BCD_W*DIGITS-1];

endmodule

// File: rtl/binary_to_bcd_hs.sv
// Serial binary-to-BCD converter with signed mode, valid/ready on both sides,
// sticky overflow and a leading-zero digit count for display blanking.
module binary_to_bcd_hs
  import bcd_pkg::*;
#(
  parameter int BITS_IN    = 16,
  parameter int BCD_DIGITS = 5,
  parameter int SIGNED     = 1,
  parameter int CNT_W      = clog2(BITS_IN + 1),
  parameter int LZ_W       = (BCD_DIGITS > 1) ? clog2(BCD_DIGITS) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          ce_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [BITS_IN-1:0]            dat_binary_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [BCD_W*BCD_DIGITS-1:0]   dat_bcd_o,
  output logic                          sign_o,
  output logic                          ovf_o,
  output logic [LZ_W-1:0]               lz_o
);

  localparam int VW = BCD_W * BCD_DIGITS;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BITS_IN - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BITS_IN-1:0]   mag_q, mag_d;
  logic [VW-1:0]        bcd_q, bcd_d;
  logic                 sign_q, sign_d;
  logic                 sticky_q, sticky_d;
  logic                 out_valid_q, out_valid_d;
  logic [VW-1:0]        dat_q, dat_d;
  logic                 sign_out_q, sign_out_d;
  logic                 ovf_q, ovf_d;
  logic [LZ_W-1:0]      lz_q, lz_d;

  logic                 sign_in_s;
  logic [BITS_IN-1:0]   mag_neg_s;
  logic [VW-1:0]        step_bcd_s;
  logic                 step_cout_s;
  logic                 accept_s;

  // Zero digits from the top, stopping at the first non-zero one; the
  // least significant digit is never counted so a zero value shows "0".
  function automatic logic [LZ_W-1:0] lead_zeros(input logic [VW-1:0] v);
    logic [LZ_W-1:0] n;
    logic            stop;
    n    = '0;
    stop = 1'b0;
    for (int i = BCD_DIGITS - 1; i >= 1; i--) begin
      if (!stop && (v[i*BCD_W +: BCD_W] == 4'd0)) begin
        n = n + LZ_W'(1);
      end else begin
        stop = 1'b1;
      end
    end
    return n;
  endfunction

  // -2^(BITS_IN-1) negates to itself, which is the correct unsigned magnitude
  assign sign_in_s = (SIGNED != 0) ? dat_binary_i[BITS_IN-1] : 1'b0;
  assign mag_neg_s = ~dat_binary_i + {{(BITS_IN-1){1'b0}}, 1'b1};

  bcd_dabble_step #(
    .DIGITS (BCD_DIGITS)
  ) u_step (
    .bcd_i  (bcd_q),
    .cin_i  (mag_q[BITS_IN-1]),
    .bcd_o  (step_bcd_s),
    .cout_o (step_cout_s)
  );

  // Ready: free in IDLE, busy in SHIFT, passes consumer ready through in DONE
  always_comb begin
    case (state_q)
      IDLE:    in_ready_o = 1'b1;
      SHIFT:   in_ready_o = 1'b0;
      DONE:    in_ready_o = out_ready_i;
      default: in_ready_o = 1'b0;
    endcase
  end

  assign accept_s = in_ready_o & in_valid_i;

  // Next-state, datapath and output-register loads
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mag_d       = mag_q;
    bcd_d       = bcd_q;
    sign_d      = sign_q;
    sticky_d    = sticky_q;
    out_valid_d = out_valid_q;
    dat_d       = dat_q;
    sign_out_d  = sign_out_q;
    ovf_d       = ovf_q;
    lz_d        = lz_q;

    case (state_q)
      IDLE: begin
        state_d = state_q;
      end
      SHIFT: begin
        if (ce_i) begin
          mag_d    = {mag_q[BITS_IN-2:0], 1'b0};
          bcd_d    = step_bcd_s;
          sticky_d = sticky_q | step_cout_s;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            dat_d       = step_bcd_s;
            sign_out_d  = sign_q;
            ovf_d       = sticky_q | step_cout_s;
            lz_d        = lead_zeros(step_bcd_s);
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            state_d = SHIFT;
          end
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    // Acceptance overrides the DONE->IDLE move for zero-bubble back-to-back
    if (accept_s) begin
      mag_d    = sign_in_s ? mag_neg_s : dat_binary_i;
      sign_d   = sign_in_s;
      bcd_d    = '0;
      sticky_d = 1'b0;
      cnt_d    = '0;
      state_d  = SHIFT;
    end else begin
      sign_d = sign_d;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mag_q       <= '0;
      bcd_q       <= '0;
      sign_q      <= 1'b0;
      sticky_q    <= 1'b0;
      out_valid_q <= 1'b0;
      dat_q       <= '0;
      sign_out_q  <= 1'b0;
      ovf_q       <= 1'b0;
      lz_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mag_q       <= mag_d;
      bcd_q       <= bcd_d;
      sign_q      <= sign_d;
      sticky_q    <= sticky_d;
      out_valid_q <= out_valid_d;
      dat_q       <= dat_d;
      sign_out_q  <= sign_out_d;
      ovf_q       <= ovf_d;
      lz_q        <= lz_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign dat_bcd_o   = dat_q;
  assign sign_o      = sign_out_q;
  assign ovf_o       = ovf_q;
  assign lz_o        = lz_q;

endmodule

// File: tb/tb_binary_to_bcd_hs.sv
// Three converters share one stimulus stream: signed 5-digit (a),
// unsigned 5-digit (b) and unsigned 4-digit (c) for overflow cases.
module tb_binary_to_bcd_hs;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] dat = 16'h0000;

  logic        in_ready_a, in_ready_b, in_ready_c;
  logic        out_valid_a, out_valid_b, out_valid_c;
  logic [19:0] bcd_a, bcd_b;
  logic [15:0] bcd_c;
  logic        sign_a, sign_b, sign_c;
  logic        ovf_a, ovf_b, ovf_c;
  logic [2:0]  lz_a, lz_b;
  logic [1:0]  lz_c;

  int n_vec = 0;
  int n_err = 0;
  int lat;

  always #5 clk = ~clk;

  binary_to_bcd_hs #(.BITS_IN(16), .BCD_DIGITS(5), .SIGNED(1)) dut_a (
    .clk_i(clk), .rst_i(rst), .ce_i(ce), .in_valid_i(in_valid), .in_ready_o(in_ready_a),
    .dat_binary_i(dat), .out_valid_o(out_valid_a), .out_ready_i(out_ready),
    .dat_bcd_o(bcd_a), .sign_o(sign_a), .ovf_o(ovf_a), .lz_o(lz_a));

  binary_to_bcd_hs #(.BITS_IN(16), .BCD_DIGITS(5), .SIGNED(0)) dut_b (
    .clk_i(clk), .rst_i(rst), .ce_i(ce), .in_valid_i(in_valid), .in_ready_o(in_ready_b),
    .dat_binary_i(dat), .out_valid_o(out_valid_b), .out_ready_i(out_ready),
    .dat_bcd_o(bcd_b), .sign_o(sign_b), .ovf_o(ovf_b), .lz_o(lz_b));

  binary_to_bcd_hs #(.BITS_IN(16), .BCD_DIGITS(4), .SIGNED(0)) dut_c (
    .clk_i(clk), .rst_i(rst), .ce_i(ce), .in_valid_i(in_valid), .in_ready_o(in_ready_c),
    .dat_binary_i(dat), .out_valid_o(out_valid_c), .out_ready_i(out_ready),
    .dat_bcd_o(bcd_c), .sign_o(sign_c), .ovf_o(ovf_c), .lz_o(lz_c));

  typedef struct {
    logic [15:0] din;
    logic [19:0] bcd_s;
    logic        sign_s;
    logic [2:0]  lz_s;
    logic [19:0] bcd_u;
    logic [2:0]  lz_u;
    logic [15:0] bcd4;
    logic        ovf4;
    logic [1:0]  lz4;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic accept(input logic [15:0] din);
    @(negedge clk);
    dat = din;
    in_valid = 1'b1;
    #1;
    chk("in_ready_idle", 32'(in_ready_a), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input bit toggle, output int cycles);
    if (toggle) ce = 1'b0;
    cycles = 0;
    while (!out_valid_a && cycles < 200) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      if (toggle) ce = ~ce;
    end
    ce = 1'b1;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("valid_dropped", 32'(out_valid_a), 32'd0);
    chk("ready_after_take", 32'(in_ready_a), 32'd1);
  endtask

  initial begin
    vecs[0]  = '{16'hFFFF, 20'h00001, 1'b1, 3'd4, 20'h65535, 3'd0, 16'h5535, 1'b1, 2'd0};
    vecs[1]  = '{16'hFB2E, 20'h01234, 1'b1, 3'd1, 20'h64302, 3'd0, 16'h4302, 1'b1, 2'd0};
    vecs[2]  = '{16'h0000, 20'h00000, 1'b0, 3'd4, 20'h00000, 3'd4, 16'h0000, 1'b0, 2'd3};
    vecs[3]  = '{16'h8000, 20'h32768, 1'b1, 3'd0, 20'h32768, 3'd0, 16'h2768, 1'b1, 2'd0};
    vecs[4]  = '{16'h3039, 20'h12345, 1'b0, 3'd0, 20'h12345, 3'd0, 16'h2345, 1'b1, 2'd0};
    vecs[5]  = '{16'h7FFF, 20'h32767, 1'b0, 3'd0, 20'h32767, 3'd0, 16'h2767, 1'b1, 2'd0};
    vecs[6]  = '{16'h270F, 20'h09999, 1'b0, 3'd1, 20'h09999, 3'd1, 16'h9999, 1'b0, 2'd0};
    vecs[7]  = '{16'h2710, 20'h10000, 1'b0, 3'd0, 20'h10000, 3'd0, 16'h0000, 1'b1, 2'd3};
    vecs[8]  = '{16'h002A, 20'h00042, 1'b0, 3'd3, 20'h00042, 3'd3, 16'h0042, 1'b0, 2'd2};
    vecs[9]  = '{16'hFFD6, 20'h00042, 1'b1, 3'd3, 20'h65494, 3'd0, 16'h5494, 1'b1, 2'd0};
    vecs[10] = '{16'h0005, 20'h00005, 1'b0, 3'd4, 20'h00005, 3'd4, 16'h0005, 1'b0, 2'd3};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready_a", 32'(in_ready_a), 32'd1);
    chk("rst_in_ready_bc", 32'({in_ready_b, in_ready_c}), 32'd3);
    chk("rst_out_valid", 32'({out_valid_a, out_valid_b, out_valid_c}), 32'd0);
    chk("rst_bcd", 32'(bcd_a), 32'd0);
    chk("rst_flags", 32'({sign_a, ovf_a, lz_a}), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      accept(vecs[i].din);
      chk("busy_in_shift", 32'(in_ready_a), 32'd0);
      wait_done(1'b0, lat);
      chk("latency", 32'(lat), 32'd16);
      chk("valid_bc", 32'({out_valid_b, out_valid_c}), 32'd3);
      chk("bcd_signed", 32'(bcd_a), 32'(vecs[i].bcd_s));
      chk("sign_signed", 32'(sign_a), 32'(vecs[i].sign_s));
      chk("lz_signed", 32'(lz_a), 32'(vecs[i].lz_s));
      chk("ovf_5digit", 32'({ovf_a, ovf_b}), 32'd0);
      chk("bcd_unsigned", 32'(bcd_b), 32'(vecs[i].bcd_u));
      chk("lz_unsigned", 32'(lz_b), 32'(vecs[i].lz_u));
      chk("sign_unsigned", 32'({sign_b, sign_c}), 32'd0);
      chk("bcd_4digit", 32'(bcd_c), 32'(vecs[i].bcd4));
      chk("ovf_4digit", 32'(ovf_c), 32'(vecs[i].ovf4));
      chk("lz_4digit", 32'(lz_c), 32'(vecs[i].lz4));
      release_out();
    end

    // ce toggling halves the step rate, then a 5-cycle output stall
    accept(16'd99);
    wait_done(1'b1, lat);
    chk("latency_ce_toggle", 32'(lat), 32'd32);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("stall_valid", 32'(out_valid_a), 32'd1);
      chk("stall_bcd", 32'(bcd_a), 32'h00099);
      chk("stall_lz", 32'(lz_a), 32'd3);
    end

    // Take result and offer next word on the same edge
    out_ready = 1'b1;
    in_valid = 1'b1;
    dat = 16'd42;
    #1;
    chk("b2b_in_ready", 32'(in_ready_a), 32'd1);
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("b2b_valid_dropped", 32'(out_valid_a), 32'd0);
    chk("b2b_now_shifting", 32'(in_ready_a), 32'd0);
    wait_done(1'b0, lat);
    chk("b2b_latency", 32'(lat), 32'd16);
    chk("b2b_bcd", 32'(bcd_a), 32'h00042);
    release_out();

    // Reset at shift step 7 discards the conversion
    accept(16'd12345);
    repeat (7) @(negedge clk);
    chk("pre_rst_busy", 32'(in_ready_a), 32'd0);
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(in_ready_a), 32'd1);
    chk("midrst_valid", 32'(out_valid_a), 32'd0);
    chk("midrst_bcd", 32'(bcd_a), 32'd0);
    chk("midrst_lz", 32'(lz_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    accept(16'd42);
    wait_done(1'b0, lat);
    chk("post_rst_latency", 32'(lat), 32'd16);
    chk("post_rst_bcd", 32'(bcd_a), 32'h00042);
    chk("post_rst_sign", 32'(sign_a), 32'd0);
    release_out();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
